exec_unit: RTL and testbench

//  Functional unit directly downstream of the operand queue (reservation station).
//  - Pops one ready entry (op, data, label) from the queue through the require/requireAC handshake.
//  - Executes the entry: op=0 is a 1-cycle increment; op=1 is a multi-cycle shift-add square.
//  - Requests the common data bus (CDB) and broadcasts the result as {BCEN, BClabel, BCdata}.

---
 rtl/exec_unit.sv | 103 ++++++++++
 tb/tb_exec_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execution unit fed by the operand queue: pops one entry, runs an increment
// or a shift-add square, then broadcasts {label, result} on the CDB.
module exec_unit #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 5,
    parameter int MUL_W   = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               require,
    input  logic               opIn,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic [LABEL_W-1:0] labelIn,
    output logic               requireAC,
    input  logic               flush,
    output logic               cdbReq,
    input  logic               cdbGrant,
    output logic               BCEN,
    output logic [LABEL_W-1:0] BClabel,
    output logic [DATA_W-1:0]  BCdata,
    output logic               busy
);

    localparam int CNT_W = $clog2(MUL_W);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT
    } state_t;

    state_t             state_q;
    logic               op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]  mcand_q;
    logic [MUL_W-1:0]   mplier_q;
    logic [LABEL_W-1:0] res_label_q;
    logic [DATA_W-1:0]  res_data_q;
    logic [DATA_W-1:0]  acc_d;

    assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

    // RST gates the accept so the queue never pops while the unit is held in reset
    assign requireAC = (state_q == IDLE) & require & ~flush & ~RST;
    assign cdbReq    = (state_q == WAIT);
    assign busy      = (state_q != IDLE);
    assign BCEN      = cdbReq & cdbGrant & ~flush;
    assign BClabel   = cdbReq ? res_label_q : '0;
    assign BCdata    = cdbReq ? res_data_q : '0;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            res_label_q <= '0;
            res_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (requireAC) begin
                        op_q        <= opIn;
                        res_label_q <= labelIn;
                        res_data_q  <= dataIn;
                        acc_q       <= '0;
                        mcand_q     <= DATA_W'(dataIn[MUL_W-1:0]);
                        mplier_q    <= dataIn[MUL_W-1:0];
                        cnt_q       <= '0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (!op_q) begin
                        res_data_q <= res_data_q + DATA_W'(1);
                        state_q    <= WAIT;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(MUL_W - 1)) begin
                            res_data_q <= acc_d;
                            state_q    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush || BCEN) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference of increment / 16-bit square.
module tb_exec_unit;

    logic        clk;
    logic        RST;
    logic        require;
    logic        opIn;
    logic [31:0] dataIn;
    logic [4:0]  labelIn;
    logic        requireAC;
    logic        flush;
    logic        cdbReq;
    logic        cdbGrant;
    logic        BCEN;
    logic [4:0]  BClabel;
    logic [31:0] BCdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    exec_unit #(.DATA_W(32), .LABEL_W(5), .MUL_W(16)) dut (
        .clk      (clk),
        .RST      (RST),
        .require  (require),
        .opIn     (opIn),
        .dataIn   (dataIn),
        .labelIn  (labelIn),
        .requireAC(requireAC),
        .flush    (flush),
        .cdbReq   (cdbReq),
        .cdbGrant (cdbGrant),
        .BCEN     (BCEN),
        .BClabel  (BClabel),
        .BCdata   (BCdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic logic [31:0] ref_res(input bit op, input logic [31:0] d);
        logic [31:0] lo;
        lo = {16'b0, d[15:0]};
        if (op) return lo * lo;
        return d + 32'd1;
    endfunction

    function automatic int ref_lat(input bit op);
        return op ? 17 : 2;
    endfunction

    // Presents one entry, then follows it to its broadcast. Edge numbers count
    // posedges after the accept edge; the grant is withheld for gdelay cycles
    // of cdbReq.
    task automatic do_op(input bit op, input logic [31:0] d, input logic [4:0] lb,
                         input int gdelay, input bit hold_req,
                         output bit acc_ok, output int req_edge, output int bc_edge,
                         output logic [4:0] bl, output logic [31:0] bd,
                         output int bad_ac, output int idle_cyc, output int nreq);
        int waited;
        @(negedge clk);
        opIn = op; dataIn = d; labelIn = lb;
        require = 1'b1; cdbGrant = 1'b0; flush = 1'b0;
        #1 acc_ok = requireAC;
        @(posedge clk);
        #1;
        require = hold_req;
        opIn = 1'($urandom); dataIn = $urandom; labelIn = 5'($urandom);
        req_edge = -1; bc_edge = -1; bad_ac = 0; idle_cyc = 0; waited = 0;
        bl = '0; bd = '0;
        for (int n = 0; n < 100 && bc_edge < 0; n++) begin
            @(negedge clk);
            if (cdbReq && req_edge < 0) req_edge = n + 1;
            if (cdbReq) begin
                if (waited >= gdelay) cdbGrant = 1'b1;
                waited++;
            end
            #1;
            if (requireAC) bad_ac++;
            if (!busy) idle_cyc++;
            if (BCEN) begin
                bc_edge = n + 1; bl = BClabel; bd = BCdata;
            end
            @(posedge clk);
            #1 cdbGrant = 1'b0;
        end
        nreq = waited;
    endtask

    task automatic test_reset();
        RST = 1'b1; require = 1'b1; cdbGrant = 1'b1; flush = 1'b0;
        opIn = 1'b0; dataIn = 32'd5; labelIn = 5'd1;
        #2;
        checks++; if (requireAC !== 1'b0) begin errors++; $display("FAIL rst_requireAC: got %b want 0", requireAC); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (cdbReq !== 1'b0) begin errors++; $display("FAIL rst_cdbReq: got %b want 0", cdbReq); end
        checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL rst_BCEN: got %b want 0", BCEN); end
        checks++; if (BClabel !== 5'd0) begin errors++; $display("FAIL rst_BClabel: got %h want 0", BClabel); end
        checks++; if (BCdata !== 32'd0) begin errors++; $display("FAIL rst_BCdata: got %h want 0", BCdata); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy: got %b want 0", busy); end
        @(negedge clk);
        RST = 1'b0; require = 1'b0; cdbGrant = 1'b0;
    endtask

    task automatic test_inc();
        bit ok; int re, be, bac, idl, nr, pulses;
        logic [4:0] bl; logic [31:0] bd;
        do_op(1'b0, 32'd20, 5'd4, 0, 1'b0, ok, re, be, bl, bd, bac, idl, nr);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL inc_accept: got %b want 1", ok); end
        checks++; if (re !== 2) begin errors++; $display("FAIL inc_req_edge: got %0d want 2", re); end
        checks++; if (be !== 2) begin errors++; $display("FAIL inc_bc_edge: got %0d want 2", be); end
        checks++; if (bl !== 5'd4) begin errors++; $display("FAIL inc_label: got %0d want 4", bl); end
        checks++; if (bd !== 32'd21) begin errors++; $display("FAIL inc_data: got %0d want 21", bd); end
        cdbGrant = 1'b1; pulses = 0;
        repeat (6) begin @(negedge clk); #1 if (BCEN) pulses++; end
        cdbGrant = 1'b0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL inc_single_pulse: got %0d extra want 0", pulses); end
    endtask

    task automatic test_square();
        bit ok; int re, be, bac, idl, nr;
        logic [4:0] bl; logic [31:0] bd;
        do_op(1'b1, 32'h0001_0003, 5'd5, 0, 1'b0, ok, re, be, bl, bd, bac, idl, nr);
        checks++; if (re !== 17) begin errors++; $display("FAIL sq_req_edge: got %0d want 17", re); end
        checks++; if (be !== 17) begin errors++; $display("FAIL sq_bc_edge: got %0d want 17", be); end
        checks++; if (bl !== 5'd5) begin errors++; $display("FAIL sq_label: got %0d want 5", bl); end
        checks++; if (bd !== 32'd9) begin errors++; $display("FAIL sq_data3: got %h want 9", bd); end
        do_op(1'b1, 32'h0000_FFFF, 5'd0, 0, 1'b0, ok, re, be, bl, bd, bac, idl, nr);
        checks++; if (bd !== 32'hFFFE_0001) begin errors++; $display("FAIL sq_dataFFFF: got %h want fffe0001", bd); end
        checks++; if (bl !== 5'd0) begin errors++; $display("FAIL sq_label0: got %0d want 0", bl); end
        do_op(1'b1, 32'hABCD_0000, 5'd31, 0, 1'b0, ok, re, be, bl, bd, bac, idl, nr);
        checks++; if (bd !== 32'd0) begin errors++; $display("FAIL sq_data0: got %h want 0", bd); end
    endtask

    task automatic test_stall();
        bit ok; int re, be, bac, idl, nr;
        logic [4:0] bl; logic [31:0] bd;
        do_op(1'b0, 32'hFFFF_FFFF, 5'd6, 5, 1'b1, ok, re, be, bl, bd, bac, idl, nr);
        checks++; if (re !== 2) begin errors++; $display("FAIL stall_req_edge: got %0d want 2", re); end
        checks++; if (nr !== 6) begin errors++; $display("FAIL stall_req_cycles: got %0d want 6", nr); end
        checks++; if (be !== 7) begin errors++; $display("FAIL stall_bc_edge: got %0d want 7", be); end
        checks++; if (bac !== 0) begin errors++; $display("FAIL stall_no_accept: got %0d accepts want 0", bac); end
        checks++; if (idl !== 0) begin errors++; $display("FAIL stall_busy: got %0d idle cycles want 0", idl); end
        checks++; if (bd !== 32'd0) begin errors++; $display("FAIL stall_wrap: got %h want 0", bd); end
        checks++; if (bl !== 5'd6) begin errors++; $display("FAIL stall_label: got %0d want 6", bl); end
        checks++; if (requireAC !== 1'b1) begin errors++; $display("FAIL stall_reaccept: got %b want 1", requireAC); end
        require = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit qo[$]; logic [4:0] ql[$]; logic [31:0] qd[$];
        logic [4:0] el[$]; logic [31:0] ed[$];
        int acc_n, bc_n, overlap, gap_bad, wrong, last_bc;
        logic [4:0] xl; logic [31:0] xd;
        qo.push_back(1'b0); ql.push_back(5'd2); qd.push_back($urandom);
        qo.push_back(1'b1); ql.push_back(5'd8); qd.push_back($urandom);
        acc_n = 0; bc_n = 0; overlap = 0; gap_bad = 0; wrong = 0; last_bc = -10;
        cdbGrant = 1'b1; flush = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (qd.size() > 0) begin
                require = 1'b1; opIn = qo[0]; dataIn = qd[0]; labelIn = ql[0];
            end else begin
                require = 1'b0;
            end
            #1;
            if (BCEN) begin
                bc_n++; last_bc = c;
                if (el.size() == 0) wrong++;
                else begin
                    xl = el.pop_front(); xd = ed.pop_front();
                    if (BClabel !== xl || BCdata !== xd) wrong++;
                end
            end
            if (requireAC && busy) overlap++;
            if (requireAC) begin
                acc_n++;
                if (acc_n == 2 && c != last_bc + 1) gap_bad++;
                el.push_back(ql[0]); ed.push_back(ref_res(qo[0], qd[0]));
                void'(qo.pop_front()); void'(ql.pop_front()); void'(qd.pop_front());
            end
        end
        require = 1'b0; cdbGrant = 1'b0;
        checks++; if (acc_n !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", acc_n); end
        checks++; if (bc_n !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", bc_n); end
        checks++; if (wrong !== 0) begin errors++; $display("FAIL b2b_order: got %0d bad broadcasts want 0", wrong); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL b2b_gap: got %0d late accepts want 0", gap_bad); end
    endtask

    task automatic test_flush();
        bit ok; int re, be, bac, idl, nr, pulses;
        logic [4:0] bl; logic [31:0] bd;
        @(negedge clk);
        cdbGrant = 1'b1; opIn = 1'b1; dataIn = $urandom; labelIn = 5'd7; require = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1 require = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_exec_busy: got %b want 1", busy); end
        @(posedge clk);
        #1 flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_exec_idle: got %b want 0", busy); end
        pulses = 0;
        repeat (25) begin @(negedge clk); #1 if (BCEN) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_exec_nobc: got %0d want 0", pulses); end

        @(negedge clk);
        cdbGrant = 1'b0; opIn = 1'b0; dataIn = $urandom; labelIn = 5'd9; require = 1'b1;
        @(posedge clk);
        #1 require = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cdbGrant = 1'b1; flush = 1'b1;
        #1;
        checks++; if (cdbReq !== 1'b1) begin errors++; $display("FAIL flush_grant_req: got %b want 1", cdbReq); end
        checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL flush_grant_bcen: got %b want 0", BCEN); end
        @(posedge clk);
        #1 flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_grant_idle: got %b want 0", busy); end
        pulses = 0;
        repeat (5) begin @(negedge clk); #1 if (BCEN) pulses++; end
        cdbGrant = 1'b0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_grant_nobc: got %0d want 0", pulses); end

        @(negedge clk);
        require = 1'b1; flush = 1'b1;
        #1;
        checks++; if (requireAC !== 1'b0) begin errors++; $display("FAIL flush_idle_block: got %b want 0", requireAC); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
        require = 1'b0; flush = 1'b0;

        do_op(1'b1, 32'h0000_0100, 5'd3, 1, 1'b0, ok, re, be, bl, bd, bac, idl, nr);
        checks++; if (bd !== 32'h0001_0000) begin errors++; $display("FAIL flush_next_data: got %h want 00010000", bd); end
        checks++; if (be !== 18) begin errors++; $display("FAIL flush_next_edge: got %0d want 18", be); end
    endtask

    task automatic test_async_reset();
        bit ok; int re, be, bac, idl, nr, pulses;
        logic [4:0] bl; logic [31:0] bd;
        @(negedge clk);
        opIn = 1'b1; dataIn = $urandom; labelIn = 5'd11; require = 1'b1; cdbGrant = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3 RST = 1'b1;
        #1;
        checks++; if ({requireAC, busy, cdbReq, BCEN, BClabel, BCdata} !== 41'd0) begin
            errors++; $display("FAIL arst_exec_outs: got %b%b%b%b %h %h want all 0",
                               requireAC, busy, cdbReq, BCEN, BClabel, BCdata);
        end
        @(negedge clk);
        RST = 1'b0; require = 1'b0;
        pulses = 0;
        repeat (20) begin @(negedge clk); #1 if (BCEN) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL arst_exec_nobc: got %0d want 0", pulses); end

        @(negedge clk);
        cdbGrant = 1'b0; opIn = 1'b0; dataIn = 32'd77; labelIn = 5'd12; require = 1'b1;
        @(posedge clk);
        #1 require = 1'b0;
        @(posedge clk);
        #2;
        checks++; if (cdbReq !== 1'b1) begin errors++; $display("FAIL arst_wait_req: got %b want 1", cdbReq); end
        cdbGrant = 1'b1; require = 1'b1; RST = 1'b1;
        #1;
        checks++; if ({requireAC, busy, cdbReq, BCEN, BClabel, BCdata} !== 41'd0) begin
            errors++; $display("FAIL arst_wait_outs: got %b%b%b%b %h %h want all 0",
                               requireAC, busy, cdbReq, BCEN, BClabel, BCdata);
        end
        @(negedge clk);
        RST = 1'b0; require = 1'b0; cdbGrant = 1'b0;

        do_op(1'b0, 32'd30, 5'd2, 0, 1'b0, ok, re, be, bl, bd, bac, idl, nr);
        checks++; if (bd !== 32'd31) begin errors++; $display("FAIL arst_fresh_data: got %0d want 31", bd); end
        checks++; if (bl !== 5'd2) begin errors++; $display("FAIL arst_fresh_label: got %0d want 2", bl); end
    endtask

    task automatic test_random();
        bit ok; int re, be, bac, idl, nr, gd;
        bit op; logic [31:0] d; logic [4:0] lb;
        logic [4:0] bl; logic [31:0] bd;
        for (int i = 0; i < 30; i++) begin
            op = 1'($urandom); d = $urandom; lb = 5'($urandom);
            gd = $urandom_range(0, 4);
            do_op(op, d, lb, gd, 1'($urandom), ok, re, be, bl, bd, bac, idl, nr);
            checks++; if (bd !== ref_res(op, d)) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, bd, ref_res(op, d)); end
            checks++; if (bl !== lb) begin errors++; $display("FAIL rnd_label[%0d]: got %0d want %0d", i, bl, lb); end
            checks++; if (be !== ref_lat(op) + gd) begin errors++; $display("FAIL rnd_edge[%0d]: got %0d want %0d", i, be, ref_lat(op) + gd); end
            checks++; if (bac !== 0) begin errors++; $display("FAIL rnd_busy_accept[%0d]: got %0d want 0", i, bac); end
            require = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_square();
        test_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
